// File: rtl/rgb_led_pkg.sv
// -----------------------------------------------------------------------------
// rgb_led_pkg
// Shared definitions for the RGB LED scheduler slice:
//   - state_t           : scheduler FSM states (OFF, WARM, ARB, HOLD)
//   - DUTY_W_DEFAULT    : default duty / PWM counter width
//   - RED, GREEN, BLUE  : slot positions of each colour duty inside one
//                         {red,green,blue} req_rgb entry (in units of DUTY_W)
// -----------------------------------------------------------------------------
package rgb_led_pkg;

    typedef enum logic [1:0] {
        OFF  = 2'b00,
        WARM = 2'b01,
        ARB  = 2'b10,
        HOLD = 2'b11
    } state_t;

    localparam int DUTY_W_DEFAULT = 32'd8;

    localparam int RED   = 32'd2;
    localparam int GREEN = 32'd1;
    localparam int BLUE  = 32'd0;

endpackage

// File: rtl/rgb_pwm_gen.sv
// -----------------------------------------------------------------------------
// rgb_pwm_gen
// Prescaler, PWM frame counter, three duty registers and comparators.
// Ports:
//   hw_clk, rst        clock and synchronous active-high reset
//   clr                restart prescaler and PWM counter at the frame start
//   load               capture load_rgb into the duty registers
//   load_rgb           {red,green,blue} duties to capture
//   hold               scheduler is in HOLD; PWM is forced low otherwise
//   pwm_red/green/blue registered PWM outputs (1 cycle after pwm count)
//   frame_end          high on the last tick of each PWM frame
// -----------------------------------------------------------------------------
module rgb_pwm_gen
    import rgb_led_pkg::*;
#(
    parameter int DUTY_W   = DUTY_W_DEFAULT,
    parameter int PRESCALE = 32'd64
) (
    input  logic                hw_clk,
    input  logic                rst,
    input  logic                clr,
    input  logic                load,
    input  logic [3*DUTY_W-1:0] load_rgb,
    input  logic                hold,
    output logic                pwm_red,
    output logic                pwm_green,
    output logic                pwm_blue,
    output logic                frame_end
);

    localparam int PS_W = (PRESCALE > 32'd1) ? $clog2(PRESCALE) : 32'd1;
    localparam logic [PS_W-1:0]   PS_LAST  = PS_W'(PRESCALE - 32'd1);
    localparam logic [PS_W-1:0]   PS_ONE   = PS_W'(32'd1);
    localparam logic [DUTY_W-1:0] CNT_ONE  = DUTY_W'(32'd1);
    localparam logic [DUTY_W-1:0] CNT_LAST = {DUTY_W{1'b1}};

    logic [PS_W-1:0]   presc_r;
    logic [PS_W-1:0]   presc_nxt_s;
    logic [DUTY_W-1:0] cnt_r;
    logic [DUTY_W-1:0] cnt_nxt_s;
    logic [DUTY_W-1:0] duty_red_r;
    logic [DUTY_W-1:0] duty_green_r;
    logic [DUTY_W-1:0] duty_blue_r;
    logic              tick_s;

    // Next prescaler and PWM count; clr wins so a new slot starts a clean frame.
    always_comb begin
        tick_s      = (presc_r == PS_LAST);
        presc_nxt_s = presc_r;
        cnt_nxt_s   = cnt_r;
        if (clr) begin
            presc_nxt_s = '0;
            cnt_nxt_s   = '0;
        end else if (tick_s) begin
            presc_nxt_s = '0;
            cnt_nxt_s   = cnt_r + CNT_ONE;
        end else begin
            presc_nxt_s = presc_r + PS_ONE;
            cnt_nxt_s   = cnt_r;
        end
    end

    // Counters, duty registers and registered outputs. frame_end is computed
    // from the next counter values so the registered pulse lines up with the
    // last tick of the frame itself rather than trailing it by a cycle.
    always_ff @(posedge hw_clk) begin
        if (rst) begin
            presc_r      <= '0;
            cnt_r        <= '0;
            duty_red_r   <= '0;
            duty_green_r <= '0;
            duty_blue_r  <= '0;
            pwm_red      <= 1'b0;
            pwm_green    <= 1'b0;
            pwm_blue     <= 1'b0;
            frame_end    <= 1'b0;
        end else begin
            presc_r   <= presc_nxt_s;
            cnt_r     <= cnt_nxt_s;
            frame_end <= (presc_nxt_s == PS_LAST) && (cnt_nxt_s == CNT_LAST);
            if (load) begin
                duty_red_r   <= load_rgb[RED*DUTY_W   +: DUTY_W];
                duty_green_r <= load_rgb[GREEN*DUTY_W +: DUTY_W];
                duty_blue_r  <= load_rgb[BLUE*DUTY_W  +: DUTY_W];
            end
            pwm_red   <= hold && (cnt_r < duty_red_r);
            pwm_green <= hold && (cnt_r < duty_green_r);
            pwm_blue  <= hold && (cnt_r < duty_blue_r);
        end
    end

endmodule

// File: rtl/rgb_led_scheduler.sv
// -----------------------------------------------------------------------------
// rgb_led_scheduler
// Time-shares the RGB LED driver between N_REQ requesters: powers up the
// driver current (curr_en), waits WARMUP cycles, then grants the LED
// round-robin in slots of HOLD_FRAMES PWM frames with led_en asserted.
// Ports:
//   hw_clk, rst        clock and synchronous active-high reset
//   req                per-requester level request
//   req_rgb            per-requester {red,green,blue} duties
//   grant              one-hot current owner, zero when none
//   pwm_red/green/blue PWM drive for RGB0PWM/RGB1PWM/RGB2PWM
//   curr_en, led_en    CURREN / RGBLEDEN
//   frame_end          pulse on the last tick of each PWM frame
// -----------------------------------------------------------------------------
module rgb_led_scheduler
    import rgb_led_pkg::*;
#(
    parameter int N_REQ       = 32'd4,
    parameter int DUTY_W      = DUTY_W_DEFAULT,
    parameter int PRESCALE    = 32'd64,
    parameter int HOLD_FRAMES = 32'd16,
    parameter int WARMUP      = 32'd1024
) (
    input  logic                      hw_clk,
    input  logic                      rst,
    input  logic [N_REQ-1:0]          req,
    input  logic [N_REQ*3*DUTY_W-1:0] req_rgb,
    output logic [N_REQ-1:0]          grant,
    output logic                      pwm_red,
    output logic                      pwm_green,
    output logic                      pwm_blue,
    output logic                      curr_en,
    output logic                      led_en,
    output logic                      frame_end
);

    localparam int IDX_W  = $clog2(N_REQ);
    localparam int WARM_W = $clog2(WARMUP + 32'd1);
    localparam int FRM_W  = $clog2(HOLD_FRAMES + 32'd1);
    localparam int ENT_W  = 3 * DUTY_W;
    localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(N_REQ - 32'd1);
    localparam logic [IDX_W-1:0]  IDX_ONE   = IDX_W'(32'd1);
    localparam logic [IDX_W:0]    IDX_WRAP  = (IDX_W + 1)'(N_REQ);
    localparam logic [WARM_W-1:0] WARM_LAST = WARM_W'(WARMUP - 32'd1);
    localparam logic [WARM_W-1:0] WARM_ONE  = WARM_W'(32'd1);
    localparam logic [FRM_W-1:0]  FRM_LAST  = FRM_W'(HOLD_FRAMES - 32'd1);
    localparam logic [FRM_W-1:0]  FRM_ONE   = FRM_W'(32'd1);
    localparam logic [N_REQ-1:0]  ONE_HOT0  = N_REQ'(32'd1);

    state_t            state_r;
    logic [IDX_W-1:0]  ptr_r;
    logic [IDX_W-1:0]  owner_r;
    logic [WARM_W-1:0] warm_cnt_r;
    logic [FRM_W-1:0]  frame_cnt_r;

    logic [N_REQ-1:0]  req_rot_s;
    logic [IDX_W:0]    sel_sum_s;
    logic [IDX_W-1:0]  sel_idx_s;
    logic              sel_found_s;
    logic [IDX_W-1:0]  load_idx_s;
    logic [IDX_W-1:0]  next_ptr_s;
    logic [ENT_W-1:0]  load_rgb_s;
    logic [N_REQ-1:0]  onehot_s;
    logic              any_req_s;
    logic              hold_s;
    logic              clr_s;
    logic              load_s;
    logic              slot_end_s;

    // Round-robin pick: rotate req so the pointer sits at bit 0, then the
    // lowest set bit (downward scan, last hit wins) is the next owner.
    always_comb begin
        req_rot_s   = N_REQ'({req, req} >> ptr_r);
        sel_found_s = 1'b0;
        sel_sum_s   = '0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            if (req_rot_s[k]) begin
                sel_found_s = 1'b1;
                sel_sum_s   = {1'b0, ptr_r} + (IDX_W + 1)'(k);
            end else begin
                sel_found_s = sel_found_s;
                sel_sum_s   = sel_sum_s;
            end
        end
        if (sel_sum_s >= IDX_WRAP) begin
            sel_idx_s = IDX_W'(sel_sum_s - IDX_WRAP);
        end else begin
            sel_idx_s = sel_sum_s[IDX_W-1:0];
        end
    end

    // Strobes to the PWM generator and slot bookkeeping. Duties come from the
    // new owner in ARB and from the current owner at every frame_end in HOLD.
    always_comb begin
        any_req_s = |req;
        hold_s    = (state_r == HOLD);
        clr_s     = (state_r == ARB) && sel_found_s;
        load_s    = clr_s || (hold_s && frame_end);
        if (state_r == ARB) begin
            load_idx_s = sel_idx_s;
        end else begin
            load_idx_s = owner_r;
        end
        load_rgb_s = req_rgb[load_idx_s*ENT_W +: ENT_W];
        slot_end_s = (frame_cnt_r == FRM_LAST) || !req[owner_r];
        if (owner_r == IDX_LAST) begin
            next_ptr_s = '0;
        end else begin
            next_ptr_s = owner_r + IDX_ONE;
        end
        onehot_s = ONE_HOT0 << sel_idx_s;
    end

    // Scheduler FSM with registered grant / enable outputs.
    always_ff @(posedge hw_clk) begin
        if (rst) begin
            state_r     <= OFF;
            ptr_r       <= '0;
            owner_r     <= '0;
            warm_cnt_r  <= '0;
            frame_cnt_r <= '0;
            grant       <= '0;
            curr_en     <= 1'b0;
            led_en      <= 1'b0;
        end else begin
            case (state_r)
                OFF: begin
                    if (any_req_s) begin
                        state_r    <= WARM;
                        warm_cnt_r <= '0;
                        curr_en    <= 1'b1;
                    end
                end
                WARM: begin
                    if (!any_req_s) begin
                        state_r <= OFF;
                        curr_en <= 1'b0;
                    end else if (warm_cnt_r == WARM_LAST) begin
                        state_r <= ARB;
                    end else begin
                        warm_cnt_r <= warm_cnt_r + WARM_ONE;
                    end
                end
                ARB: begin
                    if (sel_found_s) begin
                        state_r     <= HOLD;
                        owner_r     <= sel_idx_s;
                        frame_cnt_r <= '0;
                        grant       <= onehot_s;
                        led_en      <= 1'b1;
                    end else begin
                        state_r <= OFF;
                        curr_en <= 1'b0;
                    end
                end
                HOLD: begin
                    // Slots only ever end on a frame boundary: no partial frames.
                    if (frame_end) begin
                        if (slot_end_s) begin
                            ptr_r  <= next_ptr_s;
                            grant  <= '0;
                            led_en <= 1'b0;
                            if (any_req_s) begin
                                state_r <= ARB;
                            end else begin
                                state_r <= OFF;
                                curr_en <= 1'b0;
                            end
                        end else begin
                            frame_cnt_r <= frame_cnt_r + FRM_ONE;
                        end
                    end
                end
                default: begin
                    state_r <= OFF;
                    grant   <= '0;
                    curr_en <= 1'b0;
                    led_en  <= 1'b0;
                end
            endcase
        end
    end

    rgb_pwm_gen #(
        .DUTY_W   (DUTY_W),
        .PRESCALE (PRESCALE)
    ) u_pwm (
        .hw_clk    (hw_clk),
        .rst       (rst),
        .clr       (clr_s),
        .load      (load_s),
        .load_rgb  (load_rgb_s),
        .hold      (hold_s),
        .pwm_red   (pwm_red),
        .pwm_green (pwm_green),
        .pwm_blue  (pwm_blue),
        .frame_end (frame_end)
    );

endmodule

// File: tb/tb_rgb_led_scheduler.sv
// -----------------------------------------------------------------------------
// tb_rgb_led_scheduler
// Self-checking bench for rgb_led_scheduler with PRESCALE=1, DUTY_W=4,
// HOLD_FRAMES=2, WARMUP=4, N_REQ=4. Expected grants are queued when the
// requests are driven and compared when a new grant appears on the DUT.
// -----------------------------------------------------------------------------
module tb_rgb_led_scheduler;

    localparam int N_REQ       = 32'd4;
    localparam int DUTY_W      = 32'd4;
    localparam int PRESCALE    = 32'd1;
    localparam int HOLD_FRAMES = 32'd2;
    localparam int WARMUP      = 32'd4;

    logic                      hw_clk = 1'b0;
    logic                      rst;
    logic [N_REQ-1:0]          req;
    logic [N_REQ*3*DUTY_W-1:0] req_rgb;
    logic [N_REQ-1:0]          grant;
    logic                      pwm_red;
    logic                      pwm_green;
    logic                      pwm_blue;
    logic                      curr_en;
    logic                      led_en;
    logic                      frame_end;

    int n_checks = 0;
    int n_errors = 0;

    logic [N_REQ-1:0] exp_grant_q[$];
    logic [N_REQ-1:0] prev_grant_r = '0;

    rgb_led_scheduler #(
        .N_REQ       (N_REQ),
        .DUTY_W      (DUTY_W),
        .PRESCALE    (PRESCALE),
        .HOLD_FRAMES (HOLD_FRAMES),
        .WARMUP      (WARMUP)
    ) dut (
        .hw_clk    (hw_clk),
        .rst       (rst),
        .req       (req),
        .req_rgb   (req_rgb),
        .grant     (grant),
        .pwm_red   (pwm_red),
        .pwm_green (pwm_green),
        .pwm_blue  (pwm_blue),
        .curr_en   (curr_en),
        .led_en    (led_en),
        .frame_end (frame_end)
    );

    // Free-running clock.
    always #5 hw_clk = ~hw_clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge hw_clk);
        #1;
    endtask

    task automatic set_rgb(input int idx, input logic [3:0] r, input logic [3:0] g, input logic [3:0] b);
        req_rgb[idx*3*DUTY_W +: 3*DUTY_W] = {r, g, b};
    endtask

    // Sample len consecutive cycles starting with the current one.
    task automatic count_window(input int len, output int r, output int g, output int b, output int fe);
        r = 0; g = 0; b = 0; fe = 0;
        for (int i = 0; i < len; i++) begin
            r  += int'(pwm_red);
            g  += int'(pwm_green);
            b  += int'(pwm_blue);
            fe += int'(frame_end);
            step();
        end
    endtask

    // From a cycle with a grant: count granted cycles, then the gap until the next grant.
    task automatic run_slot(output int hold, output int gap, output int curr_low);
        hold = 0; gap = 0; curr_low = 0;
        while (grant != '0 && hold < 200) begin
            hold++;
            step();
        end
        while (grant == '0 && gap < 200) begin
            gap++;
            if (!curr_en) curr_low++;
            step();
        end
    endtask

    // Scoreboard: every newly appearing grant must match the oldest queued expectation.
    always @(negedge hw_clk) begin
        logic [N_REQ-1:0] exp_g;
        if (grant != '0 && grant != prev_grant_r) begin
            if (exp_grant_q.size() > 0) begin
                exp_g = exp_grant_q.pop_front();
                check_eq("grant", 32'(grant), 32'(exp_g));
            end else begin
                check_eq("unexpected_grant", 32'(grant), 32'd0);
            end
        end
        prev_grant_r <= grant;
    end

    // Hard time limit so the run can never hang.
    initial begin
        #100000;
        $display("FAIL timeout: observed no finish expected finish");
        $fatal(1, "time limit");
    end

    initial begin
        int r, g, b, fe, r2, g2, b2, fe2, hold, gap, low, n;

        rst = 1'b1;
        req = '0;
        req_rgb = '0;
        repeat (3) step();
        check_eq("reset_outputs",
                 32'({grant, curr_en, led_en, pwm_red, pwm_green, pwm_blue, frame_end}), 32'd0);

        // Warm-up: request at cycle 0, WARM in cycles 1..4, ARB at 5, HOLD from 6.
        rst = 1'b0;
        step();
        req = 4'b0001;
        set_rgb(0, 4'd8, 4'd0, 4'd15);
        exp_grant_q.push_back(4'b0001);
        step();
        for (int c = 1; c <= 4; c++) begin
            check_eq("warm_curr_en", 32'(curr_en), 32'd1);
            check_eq("warm_led_en", 32'(led_en), 32'd0);
            step();
        end
        check_eq("arb_curr_en", 32'(curr_en), 32'd1);
        check_eq("arb_led_en", 32'(led_en), 32'd0);
        check_eq("arb_grant", 32'(grant), 32'd0);
        step();
        check_eq("hold_led_en", 32'(led_en), 32'd1);
        check_eq("hold_grant", 32'(grant), 32'd1);
        step();
        count_window(16, r, g, b, fe);
        check_eq("pwm_red_8", 32'(r), 32'd8);
        check_eq("pwm_green_0", 32'(g), 32'd0);
        check_eq("pwm_blue_15", 32'(b), 32'd15);
        check_eq("frame_end_count", 32'(fe), 32'd1);

        // Round-robin over requesters 0,1,3 with no WARM between slots.
        req = 4'b1011;
        set_rgb(1, 4'd3, 4'd3, 4'd3);
        set_rgb(3, 4'd12, 4'd12, 4'd12);
        exp_grant_q.push_back(4'b0010);
        exp_grant_q.push_back(4'b1000);
        exp_grant_q.push_back(4'b0001);
        run_slot(hold, gap, low);
        check_eq("rr_first_gap", 32'(gap), 32'd1);
        check_eq("rr_first_curr_en_low", 32'(low), 32'd0);
        repeat (2) begin
            run_slot(hold, gap, low);
            check_eq("rr_hold", 32'(hold), 32'd32);
            check_eq("rr_gap", 32'(gap), 32'd1);
            check_eq("rr_curr_en_low", 32'(low), 32'd0);
        end

        // Early release: owner 0 drops at cnt=5, keeps the LED to the frame end, then OFF.
        repeat (5) step();
        req = '0;
        n = 0;
        while (led_en && n < 100) begin
            if (n == 3) check_eq("release_pwm_red", 32'(pwm_red), 32'd1);
            n++;
            step();
        end
        check_eq("release_led_cycles", 32'(n), 32'd11);
        check_eq("release_off", 32'({grant, curr_en, led_en}), 32'd0);
        repeat (3) step();
        check_eq("off_curr_en", 32'(curr_en), 32'd0);

        // Duty update: change mid-frame, effective only after the next frame_end.
        req = 4'b0001;
        exp_grant_q.push_back(4'b0001);
        n = 0;
        while (grant == '0 && n < 50) begin
            n++;
            step();
        end
        check_eq("warm_path_len", 32'(n), 32'd6);
        step();
        count_window(2, r, g, b, fe);
        set_rgb(0, 4'd0, 4'd15, 4'd4);
        exp_grant_q.push_back(4'b0001);
        count_window(14, r2, g2, b2, fe2);
        check_eq("old_frame_red", 32'(r + r2), 32'd8);
        check_eq("old_frame_green", 32'(g + g2), 32'd0);
        check_eq("old_frame_blue", 32'(b + b2), 32'd15);
        count_window(16, r, g, b, fe);
        check_eq("new_frame_red_0", 32'(r), 32'd0);
        check_eq("new_frame_green_15", 32'(g), 32'd15);
        check_eq("new_frame_blue_4", 32'(b), 32'd4);

        // Reset mid-HOLD: outputs clear next edge, pointer back to 0, WARM is repeated.
        repeat (4) step();
        rst = 1'b1;
        req = 4'b1011;
        exp_grant_q.push_back(4'b0001);
        step();
        check_eq("reset_mid_hold",
                 32'({grant, curr_en, led_en, pwm_red, pwm_green, pwm_blue, frame_end}), 32'd0);
        rst = 1'b0;
        step();
        check_eq("post_reset_curr_en", 32'(curr_en), 32'd1);
        check_eq("post_reset_led_en", 32'(led_en), 32'd0);
        n = 1;
        while (grant == '0 && n < 50) begin
            n++;
            step();
        end
        check_eq("post_reset_warm_len", 32'(n), 32'd6);

        // Boundary: request vanishes during WARM -> OFF, never a grant.
        rst = 1'b1;
        req = '0;
        step();
        rst = 1'b0;
        step();
        check_eq("idle_outputs", 32'({grant, curr_en, led_en}), 32'd0);
        req = 4'b0100;
        step();
        check_eq("boundary_warm_curr_en", 32'(curr_en), 32'd1);
        step();
        req = '0;
        step();
        check_eq("boundary_off_curr_en", 32'(curr_en), 32'd0);
        n = 0;
        repeat (40) begin
            if (grant != '0 || led_en) n++;
            step();
        end
        check_eq("boundary_no_grant", 32'(n), 32'd0);
        check_eq("scoreboard_drain", 32'(exp_grant_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/rgb_led_scheduler.md
Name: rgb_led_scheduler

Overview:
- Time-shares the single SB_RGBA_DRV RGB LED driver between N_REQ requesters, each of which asks for a colour as three duty values.
- Sequences the driver's current enable (CURREN) and LED enable (RGBLEDEN), then grants the LED round-robin in fixed slots of PWM frames.
- Generates glitch-free PWM for RGB0PWM/RGB1PWM/RGB2PWM.
- Sits in top between the SB_HFOSC clock domain and the SB_RGBA_DRV instance.

Parameters:
- N_REQ, 4, number of requesters (2..8).
- DUTY_W, 8, duty/PWM counter width; one frame = 2^DUTY_W PWM ticks.
- PRESCALE, 64, hw_clk cycles per PWM tick (>=1).
- HOLD_FRAMES, 16, frames per grant slot (>=1).
- WARMUP, 1024, hw_clk cycles CURREN is held before RGBLEDEN is asserted (>=1).

Ports:
- hw_clk  in  1  block clock; the SB_HFOSC CLKHF output in top.
- rst  in  1  synchronous, active-high reset.
- req  in  N_REQ  per-requester LED request, level-sensitive.
- req_rgb  in  N_REQ*3*DUTY_W  per requester {red,green,blue} duties; requester i occupies bits [i*3*DUTY_W +: 3*DUTY_W].
- grant  out  N_REQ  one-hot current owner; all zero when no owner.
- pwm_red  out  1  drives RGB0PWM.
- pwm_green  out  1  drives RGB1PWM.
- pwm_blue  out  1  drives RGB2PWM.
- curr_en  out  1  drives CURREN.
- led_en  out  1  drives RGBLEDEN.
- frame_end  out  1  single-cycle pulse on the last tick of each PWM frame.

Behaviour:
- Clock and reset: one clock (hw_clk); reset rst is synchronous and active-high.
  - All outputs 0 while rst is high.
  - On reset: state=OFF, round-robin pointer=0, prescaler, pwm_cnt, frame_cnt and duty registers cleared.
  - Reset mid-slot aborts the slot immediately, on the next edge.
- Prescaler counts 0..PRESCALE-1; tick=1 when it equals PRESCALE-1.
  - pwm_cnt (DUTY_W bits) increments on tick and wraps 2^DUTY_W-1 -> 0.
  - frame_end = tick && pwm_cnt==all-ones.
- FSM states OFF, WARM, ARB, HOLD.
  - OFF: curr_en=0, led_en=0, grant=0. Exit to WARM when |req.
  - WARM: curr_en=1. A warm counter counts WARMUP cycles, then enters ARB. If req drops to 0 during WARM, return to OFF.
  - ARB (exactly 1 cycle):
    - Select the first requester with req=1, searching from pointer upward, wrapping.
    - If none, go to OFF.
    - Otherwise: latch owner; load the duty registers from that owner's req_rgb; clear prescaler, pwm_cnt and frame_cnt; go to HOLD.
  - HOLD: curr_en=1, led_en=1, grant=onehot(owner).
    - On each frame_end, reload the duty registers from the owner's current req_rgb; this is the only mid-slot update point.
    - frame_cnt increments on each frame_end.
    - The slot ends on a frame_end where frame_cnt==HOLD_FRAMES-1, or where req[owner]==0.
    - At slot end: pointer=owner+1 (mod N_REQ); go to ARB if |req, else go to OFF. curr_en and led_en drop in the OFF cycle.
    - An owner that drops req mid-frame keeps the LED until that frame's end; there are no partial frames.
- PWM outputs:
  - pwm_x = (state==HOLD) && (pwm_cnt < duty_x), registered, so there is 1 cycle of latency from pwm_cnt.
  - Duty 0 is constant off; duty all-ones is on for 2^DUTY_W-1 of 2^DUTY_W ticks.
- WARM cost by path:
  - ARB->HOLD->ARB transitions do not revisit WARM.
  - Only the OFF->WARM path pays WARMUP.
- Grant rules:
  - A sole requester is re-granted itself after 1 ARB cycle.
  - Round-robin is fair: a continuously requesting requester waits at most N_REQ-1 slots.
- Simultaneous events:
  - A new req arriving in the same cycle as slot end is considered in ARB.
  - A req change on the ARB cycle itself is sampled in that cycle.

Decomposition:
- Shared package rgb_led_pkg holds:
  - FSM state enum (OFF, WARM, ARB, HOLD) encoded 2'b00..2'b11.
  - Default localparams for DUTY_W and the slice offsets RED=2, GREEN=1, BLUE=0 within a req_rgb entry.
- One natural sub-module, rgb_pwm_gen: prescaler, pwm_cnt, three duty registers with load strobe, three comparators, and frame_end.
- Arbitration and FSM stay in rgb_led_scheduler.

Test Plan (PRESCALE=1, DUTY_W=4, HOLD_FRAMES=2, WARMUP=4, N_REQ=4):
- Warm-up: raise req=4'b0001 at cycle 0 with req_rgb[0]={8,0,15} -> curr_en=1 from cycle 1, led_en=0 for 4 cycles, ARB at cycle 5, led_en=1 and grant=4'b0001 from cycle 6. pwm_red high 8 of 16 cycles, pwm_green never high, pwm_blue high 15 of 16 cycles.
- Round-robin: hold req=4'b1011 -> grants cycle 0001, 0010, 1000, 0001. Each slot lasts 32 HOLD cycles plus 1 ARB cycle; no WARM between slots.
- Early release: owner 0 drops req mid-frame -> PWM continues to that frame_end, then ARB. With no other req: OFF, curr_en=0 and led_en=0 the next cycle.
- Duty update: change req_rgb[owner] mid-frame -> PWM pattern changes only after the next frame_end. Duty 0 gives a flat-zero output; duty 15 gives 15/16 high.
- Reset: assert rst mid-HOLD for 1 cycle -> all outputs 0 on the next edge. Next grant starts from requester 0 and passes through WARM.
- Boundary: req drops to 0 during WARM -> return to OFF and curr_en=0; no grant is ever issued.
